// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder around one structuralFullAdder cell; SERIAL_ADDER_OVERFLOW_EN adds the overflow port.
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);
  logic ab_x, ab_a, cx_a;
  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ab_x & carryin;
  assign sum = ab_x ^ carryin;
  assign carryout = ab_a | cx_a;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  , output logic           overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0] cnt;
  logic c, fs, fc, load, last;
  structuralFullAdder fa (.a(a_sh[0]), .b(b_sh[0]), .carryin(c), .sum(fs), .carryout(fc));
  assign busy = state == RUN;
  assign done = state == DONE;
  assign r_nxt = WIDTH'({fs, r_sh} >> 1);
  always_comb begin
    load = start && state != RUN;
    last = state == RUN && cnt == CW'(WIDTH - 1);
    next = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      c <= carryin;
      cnt <= '0;
    end else if (state == RUN) begin
      r_sh <= r_nxt;
      c <= fc;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= r_nxt;
        carryout <= fc;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        overflow <= c ^ fc;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  logic clk = 0, reset = 1, start = 0, carryin = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic busy, done, carryout, overflow;
  int n_checks = 0, n_fail = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carryin(carryin),
    .busy(busy), .done(done), .sum(sum), .carryout(carryout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #250 clk = ~clk;

  task automatic start_op(input logic [7:0] xa, input logic [7:0] xb, input logic ci);
    @(negedge clk);
    a = xa; b = xb; carryin = ci; start = 1;
    @(negedge clk);
    start = 0; a = 8'hC3; b = 8'h3C; carryin = 0;
  endtask

  task automatic run_op(input string name, input logic [7:0] xa, input logic [7:0] xb, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo);
    int n = 0;
    start_op(xa, xb, ci);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 8) begin n_fail++; $display("FAIL %s busy_cycles got %0d want 8", name, n); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done got %b want 1", name, done); end
    n_checks++;
    if (sum !== es) begin n_fail++; $display("FAIL %s sum got %h want %h", name, sum, es); end
    n_checks++;
    if (carryout !== ec) begin n_fail++; $display("FAIL %s carryout got %b want %b", name, carryout, ec); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    n_checks++;
    if (overflow !== eo) begin n_fail++; $display("FAIL %s overflow got %b want %b", name, overflow, eo); end
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 0;
    n_checks++;
    if ({busy, done, sum, carryout} !== 11'b0) begin
      n_fail++; $display("FAIL reset_state got busy=%b done=%b sum=%h co=%b want all 0", busy, done, sum, carryout);
    end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
  endtask

  task automatic test_basic;
    run_op("basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
  endtask

  task automatic test_carry;
    run_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_signed;
    run_op("neg_ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("pos_ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic both = 0;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) pulses++;
      if (done && busy) both = 1;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d want 1", pulses); end
    n_checks++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_and_done got %b want 0", both); end
    n_checks++;
    if (sum !== 8'h46) begin n_fail++; $display("FAIL ignore_sum got %h want 46", sum); end
    n_checks++;
    if (carryout !== 1'b0) begin n_fail++; $display("FAIL ignore_carryout got %b want 0", carryout); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h01; carryin = 0; start = 1;
    while (!done && n < 40) begin n++; @(negedge clk); end
    n_checks++;
    if (done !== 1'b1 || sum !== 8'h02) begin
      n_fail++; $display("FAIL b2b_first done=%b sum=%h want 1 02", done, sum);
    end
    a = 8'h10; b = 8'h20;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle busy got %b want 1", busy); end
    start = 0;
    n = 1;
    while (!done && n < 40) begin n++; @(negedge clk); end
    n_checks++;
    if (n !== 9) begin n_fail++; $display("FAIL b2b_latency got %0d want 9", n); end
    n_checks++;
    if (sum !== 8'h30 || carryout !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second sum=%h co=%b want 30 0", sum, carryout);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int pulses = 0;
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_checks++;
    if ({busy, done, sum, carryout} !== 11'b0) begin
      n_fail++; $display("FAIL abort_state got busy=%b done=%b sum=%h co=%b want all 0", busy, done, sum, carryout);
    end
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_done_pulses got %0d want 0", pulses); end
    run_op("after_abort", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder sitting directly on top of the one-bit full-adder cell: it holds two WIDTH-bit operands in shift registers, feeds one bit pair per clock into a single `structuralFullAdder` instance, and registers that cell's carryout back into its carryin. It trades WIDTH cycles of latency for one adder cell. It is the sequential consumer of the bit-slice adder and the building block for later multi-cycle arithmetic units.

## Interface

- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.
- `clk` input, 1 bit: sole clock, all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input, 1 bit: request a new addition; sampled only in IDLE or DONE.
- `a` input, WIDTH bits: operand A, captured on the edge that accepts `start`.
- `b` input, WIDTH bits: operand B, captured with `a`.
- `carryin` input, 1 bit: initial carry, captured with `a`.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse; `sum`/`carryout` are valid and newly updated.
- `sum` output, WIDTH bits: registered result; holds until the next completion.
- `carryout` output, 1 bit: registered carry out of bit WIDTH-1; holds with `sum`.
- `overflow` output, 1 bit: registered signed-overflow flag; present only with `SERIAL_ADDER_OVERFLOW_EN`.

## Operation

- The datapath is one `structuralFullAdder` instance. Its inputs are `a_sh[0]`, `b_sh[0]` and the carry register.
- Internal registers: `a_sh`, `b_sh`, result shift register `r_sh` (all WIDTH bits), carry register `c`, and a bit counter `cnt` of clog2(WIDTH) bits.
- FSM states:
  - IDLE: `start`=1 → load `a_sh`←`a`, `b_sh`←`b`, `c`←`carryin`, `cnt`←0; go to RUN. Otherwise stay in IDLE.
  - RUN: each edge performs these updates:
    - `r_sh` ← {adder sum, `r_sh`[WIDTH-1:1]}.
    - `c` ← adder carryout.
    - `a_sh` and `b_sh` shift right by one, filling with 0.
    - `cnt`←`cnt`+1.
    - On the edge where `cnt`==WIDTH-1, also load `sum` ← {adder sum, `r_sh`[WIDTH-1:1]} and `carryout` ← adder carryout, then go to DONE.
    - `start` is ignored in RUN.
  - DONE: `done`=1 for exactly this one cycle. `start`=1 → load new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Processing is LSB first. The result equals (`a`+`b`+`carryin`) mod 2^WIDTH, with `carryout` as bit WIDTH.
- `sum`, `carryout` and `overflow` change only on the completion edge or on reset.
- Input operands may change freely after the accepting edge; only captured copies are used.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `carryout`=0, `overflow`=0; internal registers are cleared to 0.
- `reset` has priority over everything else. Asserting it mid-RUN aborts the operation: no `done` pulse, and the outputs return to their reset values.
- Latency: `start` accepted on edge E0. Bits are processed on edges E1..EWIDTH. `done` is high during the cycle after EWIDTH. For WIDTH=8, that means 9 cycles from `start` acceptance to the `done` cycle, inclusive of the accept cycle.
- Throughput: with `start` held high, one result every WIDTH+1 cycles.
- `busy` is high from E1 through EWIDTH, exactly WIDTH cycles. `busy` and `done` are never high together.
- Bit-cell settling: the adder path is 3 gate levels at 50 time units each, so 150 units. The bench clock period is 500 units, giving the adder outputs ample settling time before each edge.

## Configuration

- `SERIAL_ADDER_OVERFLOW_EN` defined: the `overflow` port exists.
  - On the completion edge, `overflow` ← (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - The carry into bit WIDTH-1 is the value of `c` on that edge.
  - `overflow` holds its value with `sum`.
- Macro undefined: no `overflow` port and no overflow logic. All other behaviour is identical.

## Test plan

- WIDTH=8, `a`=0x5A, `b`=0x3C, `carryin`=0, pulse `start` → `busy` high for 8 cycles, then `done` for 1 cycle; `sum`=0x96, `carryout`=0, `overflow`=1.
- `a`=0xFF, `b`=0x01, `carryin`=0 → `sum`=0x00, `carryout`=1, `overflow`=0. Also `a`=0x00, `b`=0x00, `carryin`=1 → `sum`=0x01, `carryout`=0.
- `a`=0x80, `b`=0x80 → `sum`=0x00, `carryout`=1, `overflow`=1. Then `a`=0x7F, `b`=0x01 → `sum`=0x80, `carryout`=0, `overflow`=1.
- Start 0x12+0x34, then pulse `start` with 0xFF+0xFF on RUN cycle 3 → second request ignored; `sum`=0x46 only, and `done` pulses once.
- Hold `start`=1 with 0x01+0x01, then 0x10+0x20 on the DONE cycle → `sum`=0x02 with a `done` pulse. Next, `busy` again with no IDLE cycle, and 9 cycles later `sum`=0x30.
- Start 0xAA+0x55, assert `reset` on RUN cycle 4 → next cycle: IDLE, `busy`=0, `sum`=0, `carryout`=0, and no `done` pulse. A new `start` then completes normally.
